// File: rtl/router_port_serializer.sv
// router_port_serializer: turns upstream byte beats into the router's serial
// port protocol. Each packet is a 4-bit address nibble, PAD_CYCLES pad bits,
// then 8 payload bits per byte (LSB first), followed by a one-cycle gap.
//
// state | meaning
// IDLE  | waiting for the first beat of a packet
// ADDR  | shifting out the destination nibble, LSB first
// PAD   | pad bits (din=1) between address and payload
// DATA  | shifting out payload bits, valid_n low
// WAIT  | between bytes, next beat not yet offered
// GAP   | one idle cycle closing the packet
module router_port_serializer #(
  parameter int PAD_CYCLES = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [3:0] s_addr,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       din,
  output logic       frame_n,
  output logic       valid_n,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    PAD,
    DATA,
    WAIT,
    GAP
  } state_t;

  localparam logic [3:0] PAD_LAST = 4'(PAD_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic [3:0] addr_q;
  logic [7:0] byte_q;
  logic       last_q;

  assign cnt_nxt = cnt + 4'd1;

  // Ready is a pure state decode so upstream sees a stable value all cycle.
  assign s_ready = (state == IDLE) || (state == WAIT) ||
                   ((state == DATA) && (cnt == 4'd7) && !last_q);
  assign busy    = (state != IDLE);

  // Sequencer: outputs are registered with the values for the state being entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      addr_q  <= 4'd0;
      byte_q  <= 8'd0;
      last_q  <= 1'b0;
      din     <= 1'b0;
      frame_n <= 1'b1;
      valid_n <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (s_valid) begin
            addr_q  <= s_addr;
            byte_q  <= s_data;
            last_q  <= s_last;
            cnt     <= 4'd0;
            state   <= ADDR;
            din     <= s_addr[0];
            frame_n <= 1'b0;
            valid_n <= 1'b1;
          end
        end

        ADDR: begin
          if (cnt == 4'd3) begin
            state <= PAD;
            cnt   <= 4'd0;
            din   <= 1'b1;
          end else begin
            cnt <= cnt_nxt;
            din <= addr_q[cnt_nxt[1:0]];
          end
        end

        PAD: begin
          if (cnt == PAD_LAST) begin
            state   <= DATA;
            cnt     <= 4'd0;
            din     <= byte_q[0];
            valid_n <= 1'b0;
            frame_n <= 1'b0;
          end else begin
            cnt <= cnt_nxt;
          end
        end

        DATA: begin
          if (cnt != 4'd7) begin
            cnt     <= cnt_nxt;
            din     <= byte_q[cnt_nxt[2:0]];
            // frame_n lifts on the final bit of the packet
            frame_n <= last_q && (cnt_nxt == 4'd7);
          end else if (last_q) begin
            state   <= GAP;
            cnt     <= 4'd0;
            din     <= 1'b0;
            frame_n <= 1'b1;
            valid_n <= 1'b1;
          end else if (s_valid) begin
            byte_q  <= s_data;
            last_q  <= s_last;
            cnt     <= 4'd0;
            din     <= s_data[0];
            frame_n <= 1'b0;
            valid_n <= 1'b0;
          end else begin
            state   <= WAIT;
            cnt     <= 4'd0;
            din     <= 1'b1;
            frame_n <= 1'b0;
            valid_n <= 1'b1;
          end
        end

        WAIT: begin
          if (s_valid) begin
            byte_q  <= s_data;
            last_q  <= s_last;
            cnt     <= 4'd0;
            state   <= DATA;
            din     <= s_data[0];
            frame_n <= 1'b0;
            valid_n <= 1'b0;
          end
        end

        GAP: begin
          state   <= IDLE;
          cnt     <= 4'd0;
          din     <= 1'b0;
          frame_n <= 1'b1;
          valid_n <= 1'b1;
        end

        default: begin
          state   <= IDLE;
          cnt     <= 4'd0;
          din     <= 1'b0;
          frame_n <= 1'b1;
          valid_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_router_port_serializer.sv
// Testbench for router_port_serializer: scoreboard of accepted bytes checked
// by a serial-line monitor, plus cycle-exact scenario tasks.
module tb_router_port_serializer;

  localparam int PAD = 5;

  logic       clock = 1'b0;
  logic       reset;
  logic       s_valid;
  logic       s_ready;
  logic [3:0] s_addr;
  logic [7:0] s_data;
  logic       s_last;
  logic       din;
  logic       frame_n;
  logic       valid_n;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t sb[$];

  router_port_serializer #(.PAD_CYCLES(PAD)) dut (
    .clock   (clock),
    .reset   (reset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_addr  (s_addr),
    .s_data  (s_data),
    .s_last  (s_last),
    .din     (din),
    .frame_n (frame_n),
    .valid_n (valid_n),
    .busy    (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

  // Serial-line monitor: rebuilds address and bytes and checks them against the scoreboard.
  int         m_in = 0;
  int         m_abits = 0;
  int         m_dbit = 0;
  logic [3:0] m_addr;
  logic [7:0] m_byte;
  logic       m_fbad;
  exp_t       m_e;

  always @(negedge clock) begin
    if (reset) begin
      m_in = 0;
      sb.delete();
    end else if (m_in == 0) begin
      if (frame_n == 1'b0) begin
        m_in = 1; m_abits = 1; m_addr = {3'b000, din}; m_dbit = 0; m_fbad = 1'b0;
      end
    end else if (m_abits < 4) begin
      m_addr[m_abits] = din;
      m_abits++;
    end else if (valid_n == 1'b0) begin
      m_byte[m_dbit] = din;
      if (m_dbit < 7 && frame_n) m_fbad = 1'b1;
      if (m_dbit == 7) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL sb_empty: got byte %h addr %h, nothing expected", m_byte, m_addr);
        end else begin
          m_e = sb.pop_front();
          if ({m_addr, m_byte, frame_n, m_fbad} !== {m_e.addr, m_e.data, m_e.last, 1'b0}) begin
            fails++;
            $display("FAIL byte: got addr=%h data=%h last=%b fbad=%b, want addr=%h data=%h last=%b fbad=0",
                     m_addr, m_byte, frame_n, m_fbad, m_e.addr, m_e.data, m_e.last);
          end
        end
        m_dbit = 0;
        m_fbad = 1'b0;
        if (frame_n) m_in = 0;
      end else begin
        m_dbit++;
      end
    end else begin
      tests++;
      if ({din, frame_n} !== 2'b10) begin
        fails++;
        $display("FAIL pad_wait: got din=%b frame_n=%b, want din=1 frame_n=0", din, frame_n);
      end
    end
  end

  task automatic randomize_idle_inputs();
    s_valid = 1'b0;
    s_addr  = 4'($urandom);
    s_data  = 8'($urandom);
    s_last  = 1'($urandom);
  endtask

  task automatic push_exp(input logic [3:0] a, input logic [7:0] d, input logic l);
    exp_t e;
    e = '{addr: a, data: d, last: l};
    sb.push_back(e);
  endtask

  // Offers one packet; dly idle cycles are inserted after the DUT first becomes ready for each later byte.
  task automatic send_pkt(input logic [3:0] addr, input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input int n, input int dly);
    logic [7:0] d;
    int guard;
    int wait_left;
    for (int k = 0; k < n; k++) begin
      d = (k == 0) ? d0 : ((k == 1) ? d1 : d2);
      wait_left = (k == 0) ? 0 : dly;
      guard = 0;
      while (1) begin
        if (s_ready && wait_left == 0) break;
        if (s_ready) wait_left--;
        randomize_idle_inputs();
        @(negedge clock);
        guard++;
        if (guard > 200) begin
          tests++; fails++;
          $display("FAIL send_timeout: beat %0d got no s_ready within 200 cycles, want ready", k);
          return;
        end
      end
      s_valid = 1'b1;
      s_addr  = (k == 0) ? addr : 4'($urandom);
      s_data  = d;
      s_last  = (k == n - 1);
      push_exp(addr, d, (k == n - 1));
      @(negedge clock);
      randomize_idle_inputs();
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (busy && guard < 300) begin
      @(negedge clock);
      guard++;
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_timeout: got busy=%b, want 0", busy);
    end
    @(negedge clock);
  endtask

  task automatic observe(output int total, output int maxrun, output int pulses,
                         output int waits, output int frise);
    int run = 0;
    int guard = 0;
    total = 0; maxrun = 0; pulses = 0; waits = 0; frise = 0;
    while (!busy && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    while (busy && guard < 400) begin
      if (!valid_n) begin
        total++; run++;
        if (run > maxrun) maxrun = run;
        if (frame_n) frise++;
      end else begin
        run = 0;
      end
      if (s_ready && !valid_n) pulses++;
      if (s_ready && valid_n) waits++;
      @(negedge clock);
      guard++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    s_valid = 1'b1; s_addr = 4'h7; s_data = 8'h55; s_last = 1'b1;
    repeat (3) @(negedge clock);
    tests++;
    if ({din, frame_n, valid_n, busy, s_ready} !== 5'b01101) begin
      fails++;
      $display("FAIL reset_state: got din/frame_n/valid_n/busy/s_ready=%b, want 01101",
               {din, frame_n, valid_n, busy, s_ready});
    end
    reset = 1'b0;
    randomize_idle_inputs();
    @(negedge clock);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_no_accept: got busy=%b, want 0", busy);
    end
  endtask

  task automatic test_single_a5();
    logic [3:0] a = 4'h3;
    logic [7:0] d = 8'hA5;
    logic [4:0] exp, got;
    tests++;
    if (s_ready !== 1'b1) begin
      fails++;
      $display("FAIL a5_ready0: got s_ready=%b, want 1", s_ready);
    end
    s_valid = 1'b1; s_addr = a; s_data = d; s_last = 1'b1;
    push_exp(a, d, 1'b1);
    @(negedge clock);
    randomize_idle_inputs();
    for (int k = 1; k <= 19; k++) begin
      // expected {din, frame_n, valid_n, s_ready, busy}
      if (k <= 4)       exp = {a[k-1], 1'b0, 1'b1, 1'b0, 1'b1};
      else if (k <= 9)  exp = {1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      else if (k <= 17) exp = {d[k-10], (k == 17), 1'b0, 1'b0, 1'b1};
      else if (k == 18) exp = 5'b01101;
      else              exp = 5'b01110;
      got = {din, frame_n, valid_n, s_ready, busy};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL a5_cycle%0d: got din/frame_n/valid_n/s_ready/busy=%b, want %b", k, got, exp);
      end
      @(negedge clock);
      randomize_idle_inputs();
    end
  endtask

  task automatic test_back_to_back();
    int total, maxrun, pulses, waits, frise;
    fork
      send_pkt(4'hF, 8'h01, 8'h80, 8'hFF, 3, 0);
      observe(total, maxrun, pulses, waits, frise);
    join
    tests++;
    if ({total, maxrun, pulses, waits, frise} !== {32'd24, 32'd24, 32'd2, 32'd0, 32'd1}) begin
      fails++;
      $display("FAIL b2b: got valid=%0d run=%0d pulses=%0d waits=%0d frise=%0d, want 24 24 2 0 1",
               total, maxrun, pulses, waits, frise);
    end
    wait_idle();
  endtask

  task automatic test_stall();
    int total, maxrun, pulses, waits, frise;
    fork
      send_pkt(4'h6, 8'h5A, 8'hC3, 8'h00, 2, 3);
      observe(total, maxrun, pulses, waits, frise);
    join
    tests++;
    if ({total, maxrun, pulses, waits, frise} !== {32'd16, 32'd8, 32'd1, 32'd3, 32'd1}) begin
      fails++;
      $display("FAIL stall: got valid=%0d run=%0d pulses=%0d waits=%0d frise=%0d, want 16 8 1 3 1",
               total, maxrun, pulses, waits, frise);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    tests++;
    if (s_ready !== 1'b1) begin
      fails++;
      $display("FAIL rmid_ready0: got s_ready=%b, want 1", s_ready);
    end
    s_valid = 1'b1; s_addr = 4'hA; s_data = 8'h96; s_last = 1'b0;
    push_exp(4'hA, 8'h96, 1'b0);
    @(negedge clock);
    randomize_idle_inputs();
    repeat (12) @(negedge clock);
    tests++;
    if ({valid_n, din} !== 2'b00) begin
      fails++;
      $display("FAIL rmid_bit3: got valid_n=%b din=%b, want 0 0", valid_n, din);
    end
    reset = 1'b1;
    @(negedge clock);
    tests++;
    if ({din, frame_n, valid_n, busy} !== 4'b0110) begin
      fails++;
      $display("FAIL rmid_abort: got din/frame_n/valid_n/busy=%b, want 0110", {din, frame_n, valid_n, busy});
    end
    s_valid = 1'b1; s_addr = 4'h1; s_data = 8'hFF; s_last = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    randomize_idle_inputs();
    @(negedge clock);
    tests++;
    if ({busy, s_ready, frame_n} !== 3'b011) begin
      fails++;
      $display("FAIL rmid_after: got busy/s_ready/frame_n=%b, want 011", {busy, s_ready, frame_n});
    end
    send_pkt(4'h2, 8'h3E, 8'h00, 8'h00, 1, 0);
    wait_idle();
  endtask

  task automatic test_hold_valid();
    int acc = 0;
    int guard = 0;
    int t1 = -1;
    int t2 = -1;
    logic prev_f = 1'b1;
    s_valid = 1'b1; s_addr = 4'h5; s_data = 8'h3C; s_last = 1'b1;
    while (guard < 80 && t2 < 0) begin
      if (prev_f && !frame_n) begin
        if (t1 < 0) t1 = cyc;
        else        t2 = cyc;
      end
      prev_f = frame_n;
      if (s_ready && acc < 2) begin
        push_exp(s_addr, s_data, 1'b1);
        acc++;
      end
      @(negedge clock);
      guard++;
      if (acc == 1) begin
        s_addr = 4'h9; s_data = 8'hC3;
      end else if (acc == 2) begin
        s_valid = 1'b0;
      end
    end
    tests++;
    if ((t1 < 0) || (t2 - t1 != 19)) begin
      fails++;
      $display("FAIL hold_spacing: got ADDR start spacing %0d (t1=%0d t2=%0d), want 19", t2 - t1, t1, t2);
    end
    randomize_idle_inputs();
    wait_idle();
  endtask

  initial begin
    reset = 1'b1;
    randomize_idle_inputs();
    @(negedge clock);
    test_reset();
    test_single_a5();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_hold_valid();
    send_pkt(4'h0, 8'h00, 8'h00, 8'h00, 1, 0);
    wait_idle();
    repeat (3) @(negedge clock);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: got %0d unsent bytes, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/router_port_serializer.md
ROUTER_PORT_SERIALIZER -- requirements
Module: router_port_serializer

Interface
REQ-001 Parameter PAD_CYCLES, default 5, number of pad cycles between address nibble and first payload bit (legal 1..15).
REQ-002 clock  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-004 s_valid  input  1  upstream byte beat valid.
REQ-005 s_ready  output  1  block accepts beat this cycle; transfer when s_valid && s_ready at rising edge.
REQ-006 s_addr  input  4  destination port; sampled on first beat of a packet only, ignored otherwise.
REQ-007 s_data  input  8  payload byte, transmitted LSB first.
REQ-008 s_last  input  1  beat is last byte of packet.
REQ-009 din  output  1  serial data to one router input port.
REQ-010 frame_n  output  1  active-low packet frame.
REQ-011 valid_n  output  1  active-low payload-bit valid.
REQ-012 busy  output  1  high whenever state != IDLE.

Function
REQ-013 States SHALL be IDLE, ADDR, PAD, DATA, WAIT, GAP; din/frame_n/valid_n SHALL be registered, s_ready and busy decoded from state.
REQ-014 IDLE: din=0, frame_n=1, valid_n=1, s_ready=1; on accepted beat latch s_addr, s_data, s_last, go ADDR, bit counter=0.
REQ-015 ADDR: 4 cycles, frame_n=0, valid_n=1, din=addr[cnt] for cnt 0..3 (LSB first), then PAD.
REQ-016 PAD: exactly PAD_CYCLES cycles, frame_n=0, valid_n=1, din=1, then DATA bit 0.
REQ-017 DATA: 8 cycles per byte, valid_n=0, din=byte[bit] for bit 0..7, frame_n=0 except frame_n=1 on bit 7 of the last byte.
REQ-018 s_ready SHALL be 1 during DATA bit 7 of a non-last byte; accepted beat loads next byte, bit 0 follows next cycle with no gap.
REQ-019 DATA bit 7 of non-last byte with no accepted beat -> WAIT: frame_n=0, valid_n=1, din=1, s_ready=1 until a beat is accepted, then DATA bit 0.
REQ-020 After bit 7 of last byte -> GAP: one cycle, frame_n=1, valid_n=1, din=0, s_ready=0, then IDLE.
REQ-021 Latency: outputs for ADDR bit 0 appear in the cycle after first-beat acceptance; no-stall packet of N bytes occupies 4+PAD_CYCLES+8N cycles plus 1 GAP cycle.
REQ-022 s_valid with s_ready=0 SHALL be ignored with no state change; upstream holds beat (valid/ready rule).
REQ-023 s_last on first beat SHALL produce a single-byte packet; zero-byte packets are not representable.
REQ-024 Bit and pad counters SHALL wrap only via state transitions; no counter overflow alters output sequence.
REQ-025 s_addr, s_data, s_last changes while not accepted SHALL not affect din.

Reset
REQ-026 reset=1 at a rising edge SHALL force IDLE, din=0, frame_n=1, valid_n=1, busy=0, counters=0, from any state.
REQ-027 Reset mid-packet SHALL abort the packet: no further ADDR/PAD/DATA bits, no GAP cycle; s_ready=1 in first cycle after reset deasserts.
REQ-028 s_valid during reset SHALL not be accepted.

Verification
REQ-029 1 byte, addr=3, data=0xA5, PAD=5, accepted at edge 0 -> cycles 1-4 din=1,1,0,0 frame_n=0; cycles 5-9 din=1 valid_n=1; cycles 10-17 din=1,0,1,0,0,1,0,1 valid_n=0; frame_n=1 only at cycle 17; cycle 18 GAP; s_ready=1 cycle 19.
REQ-030 3 bytes 0x01,0x80,0xFF addr=0xF back-to-back -> 24 contiguous valid_n=0 cycles, frame_n rises on final bit, s_ready pulses at bits 7 of bytes 1 and 2 only.
REQ-031 2 bytes, second s_valid delayed 3 cycles after first byte bit 7 -> 3 WAIT cycles with frame_n=0, valid_n=1, din=1, then second byte unbroken.
REQ-032 reset asserted at DATA bit 3 of byte 1 -> next cycle frame_n=1, valid_n=1, din=0, busy=0; new packet afterwards serializes correctly.
REQ-033 s_valid held high continuously over two 1-byte packets -> second packet's ADDR begins exactly 19 cycles after first acceptance (GAP respected), s_addr of non-first beats ignored.
